// File: rtl/pulse_stretch_queue.sv
// Replays each TRIG rising edge as a fixed-width OUT pulse followed by a forced low gap.
// Edges arriving while a pulse is in progress are queued in a saturating counter.
module pulse_stretch_queue #(
    parameter int unsigned HIGH_CYC = 100,
    parameter int unsigned GAP_CYC  = 4,
    parameter int unsigned PEND_W   = 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              TRIG,
    output logic              OUT,
    output logic              BUSY,
    output logic [PEND_W-1:0] PENDING,
    output logic              OVF
);

    localparam int unsigned CNT_MAX = (HIGH_CYC > GAP_CYC) ? HIGH_CYC : GAP_CYC;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0]  CNT_HIGH = CNT_W'(HIGH_CYC - 1);
    localparam logic [CNT_W-1:0]  CNT_GAP  = CNT_W'(GAP_CYC - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [PEND_W-1:0]  pend_d;
    logic               ovf_d;
    logic               out_d;
    logic               busy_d;
    logic               trig_p;
    logic               trig_edge;
    logic               enq;

    assign trig_edge = TRIG & ~trig_p;

    // State and all output registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            trig_p  <= 1'b0;
            OUT     <= 1'b0;
            BUSY    <= 1'b0;
            PENDING <= '0;
            OVF     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            trig_p  <= TRIG;
            OUT     <= out_d;
            BUSY    <= busy_d;
            PENDING <= pend_d;
            OVF     <= ovf_d;
        end
    end

    // Next-state, counter and queue bookkeeping
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = PENDING;
        ovf_d   = OVF;
        out_d   = OUT;
        enq     = 1'b0;

        case (state_q)
            IDLE: begin
                if (trig_edge) begin
                    state_d = HIGH;
                    out_d   = 1'b1;
                    cnt_d   = CNT_HIGH;
                end
            end
            HIGH: begin
                enq = trig_edge;
                if (cnt_q == '0) begin
                    state_d = GAP;
                    out_d   = 1'b0;
                    cnt_d   = CNT_GAP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    enq   = trig_edge;
                end else if (PENDING != '0) begin
                    // An edge in this cycle replaces the dequeued event: net count unchanged
                    state_d = HIGH;
                    out_d   = 1'b1;
                    cnt_d   = CNT_HIGH;
                    if (!trig_edge) begin
                        pend_d = PENDING - PEND_W'(1);
                    end
                end else if (trig_edge) begin
                    state_d = HIGH;
                    out_d   = 1'b1;
                    cnt_d   = CNT_HIGH;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                out_d   = 1'b0;
                cnt_d   = '0;
            end
        endcase

        if (enq) begin
            if (PENDING == PEND_MAX) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = PENDING + PEND_W'(1);
            end
        end

        busy_d = (state_d != IDLE);
    end

endmodule
